// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: pipeline memory stage. It owns the data RAM and performs
// byte, halfword and word loads and stores with sign or zero extension. A
// configurable access latency is modelled, and the stage stalls the pipeline
// while an access is in flight. It also resolves the six conditional branches
// from a full compare of the two operands.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   valid_in             an instruction occupies MEM this cycle
//   alu_result           byte address for loads and stores
//   write_data           store data (rs2)
//   rs1_val, rs2_val     branch compare operands
//   mem_read/mem_write   memory op controls from EX/MEM
//   mem_branch           branch control from EX/MEM
//   funct3               access size or branch condition
//   stall                holds the upstream pipeline registers
//   valid_out            MEM result is final; MEM/WB may capture it
//   load_data            extended load result
//   mem_fault            misaligned or illegal access; no access is performed
//   pc_src               branch taken
//
// state | meaning
// IDLE  | ready; accepts a request, or passes non-memory ops straight through
// BUSY  | access in flight, cnt counts down the remaining latency
// DONE  | result presented for one cycle, then back to IDLE
module mem_stage_lsu #(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_branch,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic        valid_out,
  output logic [31:0] load_data,
  output logic        mem_fault,
  output logic        pc_src
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // With single-cycle latency the accept edge goes straight to DONE.
  localparam logic [1:0] ST_AFTER_ACCEPT = (MEM_LAT > 1) ? ST_BUSY : ST_DONE;
  localparam logic [3:0] CNT_INIT        = 4'(MEM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] load_q;

  logic [31:0] mem_q [2**ADDR_W];

  logic              is_idle, is_busy, is_done;
  logic              mem_op, f3_ok, misalign, request, accept;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lanes;
  logic [31:0]       rd_shift, ext_data;
  logic [15:0]       rd_half;
  logic              cond;
  logic              unused_addr_hi;

  assign is_idle = (state_q == ST_IDLE);
  assign is_busy = (state_q == ST_BUSY);
  assign is_done = (state_q == ST_DONE);

  // Addresses wrap: the bits above the RAM index are ignored.
  assign word_idx       = alu_result[ADDR_W+1:2];
  assign unused_addr_hi = ^alu_result[31:ADDR_W+2];

  assign mem_op = mem_read | mem_write;

  always_comb begin
    f3_ok = 1'b0;
    if (mem_read) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
  end

  // funct3[1:0]==01 covers both LH and LHU; SW/LW are the only word ops.
  assign misalign = ((funct3[1:0] == 2'b01) & alu_result[0]) |
                    ((funct3 == 3'b010) & (alu_result[1:0] != 2'b00));

  assign mem_fault = valid_in & mem_op &
                     ((mem_read & mem_write) | ~f3_ok | misalign);

  assign request = valid_in & mem_op & ~mem_fault;
  assign accept  = rst_n & is_idle & request;

  always_comb begin
    byte_en     = 4'b1111;
    wdata_lanes = write_data;
    case (funct3)
      3'b000: begin
        byte_en     = 4'b0001 << alu_result[1:0];
        wdata_lanes = {4{write_data[7:0]}};
      end
      3'b001: begin
        byte_en     = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{write_data[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        wdata_lanes = write_data;
      end
    endcase
  end

  // RAM contents survive reset; a store commits on its accept edge.
  always_ff @(posedge clk) begin
    if (accept && mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          cnt_d   = CNT_INIT;
          state_d = ST_AFTER_ACCEPT;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      addr_lo_q <= 2'd0;
      load_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_data;
      if (accept) begin
        // A store leaves the read register at zero so DONE presents 0.
        rdata_q   <= mem_read ? mem_q[word_idx] : 32'd0;
        f3_q      <= funct3;
        addr_lo_q <= alu_result[1:0];
      end
    end
  end

  assign rd_shift = rdata_q >> {addr_lo_q, 3'b000};
  assign rd_half  = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ext_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ext_data = rdata_q;
      3'b100:  ext_data = {24'd0, rd_shift[7:0]};
      3'b101:  ext_data = {16'd0, rd_half};
      default: ext_data = 32'd0;
    endcase
  end

  always_comb begin
    if (is_done)                          load_data = ext_data;
    else if (is_idle && valid_in && !request) load_data = 32'd0;
    else                                  load_data = load_q;
  end

  always_comb begin
    case (funct3)
      3'b000:  cond = (rs1_val == rs2_val);
      3'b001:  cond = (rs1_val != rs2_val);
      3'b100:  cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond = (rs1_val <  rs2_val);
      3'b111:  cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
  end

  assign pc_src    = rst_n & is_idle & valid_in & mem_branch & cond;
  assign stall     = rst_n & ((is_idle & request) | is_busy);
  assign valid_out = rst_n & ((is_idle & valid_in & ~request) | is_done);

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic [31:0] alu, wd, r1, r2;
  logic        rd, wr, br;
  logic [2:0]  f3;
  logic        valid_v [3];
  logic        rst_v   [3];
  logic        stall_o [3];
  logic        vout_o  [3];
  logic        fault_o [3];
  logic        pc_o    [3];
  logic [31:0] ld_o    [3];

  int total = 0;
  int bad   = 0;

  bit [31:0] mdl [3][1024];

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(4), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_v[0]), .valid_in(valid_v[0]), .alu_result(alu),
    .write_data(wd), .rs1_val(r1), .rs2_val(r2), .mem_read(rd), .mem_write(wr),
    .mem_branch(br), .funct3(f3), .stall(stall_o[0]), .valid_out(vout_o[0]),
    .load_data(ld_o[0]), .mem_fault(fault_o[0]), .pc_src(pc_o[0]));

  mem_stage_lsu #(.ADDR_W(10), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_v[1]), .valid_in(valid_v[1]), .alu_result(alu),
    .write_data(wd), .rs1_val(r1), .rs2_val(r2), .mem_read(rd), .mem_write(wr),
    .mem_branch(br), .funct3(f3), .stall(stall_o[1]), .valid_out(vout_o[1]),
    .load_data(ld_o[1]), .mem_fault(fault_o[1]), .pc_src(pc_o[1]));

  mem_stage_lsu #(.ADDR_W(10), .MEM_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_v[2]), .valid_in(valid_v[2]), .alu_result(alu),
    .write_data(wd), .rs1_val(r1), .rs2_val(r2), .mem_read(rd), .mem_write(wr),
    .mem_branch(br), .funct3(f3), .stall(stall_o[2]), .valid_out(vout_o[2]),
    .load_data(ld_o[2]), .mem_fault(fault_o[2]), .pc_src(pc_o[2]));

  function automatic int lat_of(int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
  endfunction

  function automatic int idx_of(int s, logic [31:0] a);
    int aw = (s == 0) ? 4 : 10;
    return int'((a >> 2) & ((32'd1 << aw) - 32'd1));
  endfunction

  // Access size in bytes for a legal op, 0 when funct3 is illegal for it.
  function automatic int size_of(bit is_rd, logic [2:0] fn);
    if (is_rd) begin
      case (fn)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    case (fn)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_fault(bit is_rd, bit is_wr, logic [2:0] fn, logic [31:0] a);
    int n;
    if (!is_rd && !is_wr) return 1'b0;
    if (is_rd && is_wr) return 1'b1;
    n = size_of(is_rd, fn);
    if (n == 0) return 1'b1;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] exp_load(int s, logic [2:0] fn, logic [31:0] a);
    logic [31:0] w, sh;
    w  = mdl[s][idx_of(s, a)];
    sh = w >> (8 * int'(a[1:0]));
    case (fn)
      3'd0:    return sh[7] ? (32'hFFFFFF00 | (sh & 32'hFF)) : (sh & 32'hFF);
      3'd1:    return sh[15] ? (32'hFFFF0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
      3'd2:    return w;
      3'd4:    return sh & 32'hFF;
      3'd5:    return sh & 32'hFFFF;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit exp_cond(logic [2:0] fn, logic [31:0] a, logic [31:0] b);
    case (fn)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(int s, bit is_rd, bit is_wr, bit is_br, logic [2:0] fn,
                       logic [31:0] a, logic [31:0] d, logic [31:0] b1,
                       logic [31:0] b2, string tag);
    bit          e_fault, got, first, e_pc;
    int          e_stall, stalls, n, lane0;
    logic [31:0] e_data, g_data;
    logic        g_fault;
    e_fault = exp_fault(is_rd, is_wr, fn, a);
    e_stall = ((is_rd || is_wr) && !e_fault) ? lat_of(s) : 0;
    e_data  = (is_rd && !e_fault) ? exp_load(s, fn, a) : 32'd0;
    e_pc    = is_br && exp_cond(fn, b1, b2);
    @(posedge clk); #1;
    alu = a; wd = d; r1 = b1; r2 = b2; rd = is_rd; wr = is_wr; br = is_br; f3 = fn;
    valid_v[s] = 1'b1;
    stalls = 0; got = 1'b0; first = 1'b1; g_data = 32'd0; g_fault = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (first) begin
        chk({tag, ".pc_src"}, 32'(pc_o[s]), 32'(e_pc));
        first = 1'b0;
      end
      if (vout_o[s]) begin
        got     = 1'b1;
        g_data  = ld_o[s];
        g_fault = fault_o[s];
      end else begin
        if (stall_o[s]) stalls++;
        @(posedge clk); #1;
      end
    end
    chk({tag, ".valid_out_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, ".stall_cycles"}, 32'(stalls), 32'(e_stall));
      chk({tag, ".mem_fault"}, 32'(g_fault), 32'(e_fault));
      chk({tag, ".load_data"}, g_data, e_data);
      @(posedge clk); #1;
      valid_v[s] = 1'b0; rd = 1'b0; wr = 1'b0; br = 1'b0;
      @(negedge clk);
      chk({tag, ".hold"}, ld_o[s], e_data);
    end
    if (is_wr && !is_rd && !e_fault) begin
      n     = size_of(1'b0, fn);
      lane0 = int'(a[1:0]);
      for (int k = 0; k < n; k++)
        mdl[s][idx_of(s, a)][8*(lane0+k) +: 8] = d[8*k +: 8];
    end
  endtask

  logic [31:0] ra, rdat, rb1, rb2;
  int          kind, rs;

  initial begin
    alu = '0; wd = '0; r1 = '0; r2 = '0; rd = 1'b1; wr = 1'b0; br = 1'b1; f3 = 3'd0;
    for (int s = 0; s < 3; s++) begin
      rst_v[s] = 1'b0;
      valid_v[s] = 1'b1;
    end
    // Outputs must stay quiet under reset even with a request on the inputs.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst.stall", 32'(stall_o[s]), 32'd0);
      chk("rst.valid_out", 32'(vout_o[s]), 32'd0);
      chk("rst.pc_src", 32'(pc_o[s]), 32'd0);
    end
    @(posedge clk); #1;
    rd = 1'b0; br = 1'b0;
    for (int s = 0; s < 3; s++) begin
      valid_v[s] = 1'b0;
      rst_v[s] = 1'b1;
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("post_rst.load_data", ld_o[s], 32'd0);
      chk("post_rst.stall", 32'(stall_o[s]), 32'd0);
    end

    for (int i = 0; i < 16; i++)
      do_op(0, 0, 1, 0, 3'd2, 32'(4 * i), $urandom, 0, 0, "init0");
    for (int i = 0; i < 4; i++)
      do_op(1, 0, 1, 0, 3'd2, 32'h100 + 32'(4 * i), $urandom, 0, 0, "init1");

    do_op(0, 0, 1, 0, 3'd2, 32'h40, 32'hDEADBEEF, 0, 0, "l1.sw");
    do_op(0, 1, 0, 0, 3'd2, 32'h40, 0, 0, 0, "l1.lw");
    chk("l1.lw_const", exp_load(0, 3'd2, 32'h40), 32'hDEADBEEF);
    do_op(0, 0, 1, 0, 3'd2, 32'h44, 32'hCAFEF00D, 0, 0, "wrap.sw");
    do_op(0, 1, 0, 0, 3'd2, 32'h04, 0, 0, 0, "wrap.lw");

    do_op(1, 0, 1, 0, 3'd2, 32'h40, 32'hDEADBEEF, 0, 0, "l3.sw");
    do_op(1, 0, 1, 0, 3'd0, 32'h41, 32'h00000080, 0, 0, "l3.sb");
    do_op(1, 1, 0, 0, 3'd0, 32'h41, 0, 0, 0, "l3.lb");
    do_op(1, 1, 0, 0, 3'd4, 32'h41, 0, 0, 0, "l3.lbu");
    do_op(1, 1, 0, 0, 3'd1, 32'h40, 0, 0, 0, "l3.lh");
    chk("l3.lh_const", exp_load(1, 3'd1, 32'h40), 32'hFFFF80EF);

    do_op(1, 1, 0, 0, 3'd2, 32'h42, 0, 0, 0, "flt.lw42");
    do_op(1, 1, 0, 0, 3'd1, 32'h43, 0, 0, 0, "flt.lh43");
    do_op(1, 0, 1, 0, 3'd2, 32'h42, 32'h11111111, 0, 0, "flt.sw42");
    do_op(1, 0, 1, 0, 3'd4, 32'h40, 32'h22222222, 0, 0, "flt.sf3");
    do_op(1, 1, 1, 0, 3'd2, 32'h40, 32'h33333333, 0, 0, "flt.rdwr");
    do_op(1, 1, 0, 0, 3'd3, 32'h40, 0, 0, 0, "flt.lf3");
    do_op(1, 1, 0, 0, 3'd2, 32'h40, 0, 0, 0, "flt.unchanged");

    do_op(1, 0, 0, 1, 3'd4, 0, 0, 32'hFFFFFFFF, 32'd1, "br.blt");
    do_op(1, 0, 0, 1, 3'd6, 0, 0, 32'hFFFFFFFF, 32'd1, "br.bltu");
    do_op(1, 0, 0, 1, 3'd7, 0, 0, 32'hFFFFFFFF, 32'd1, "br.bgeu");
    do_op(1, 0, 0, 1, 3'd1, 0, 0, 32'hFFFFFFFF, 32'd1, "br.bne");
    do_op(1, 0, 0, 1, 3'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, "br.f3_010");
    do_op(1, 0, 0, 0, 3'd4, 0, 0, 32'hFFFFFFFF, 32'd1, "br.nobranch");
    do_op(1, 0, 0, 1, 3'd0, 0, 0, 32'h5, 32'h5, "br.beq");
    do_op(1, 0, 0, 1, 3'd5, 0, 0, 32'h80000000, 32'h7FFFFFFF, "br.bge");

    // Reset in the second stall cycle of a store; the store stays committed.
    @(posedge clk); #1;
    alu = 32'h10; wd = 32'hA5A5_0F0F; wr = 1'b1; f3 = 3'd2; valid_v[2] = 1'b1;
    @(negedge clk);
    chk("mid_rst.stall1", 32'(stall_o[2]), 32'd1);
    @(posedge clk); #1;
    rst_v[2] = 1'b0; valid_v[2] = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("mid_rst.stall_in_rst", 32'(stall_o[2]), 32'd0);
    @(posedge clk); #1;
    rst_v[2] = 1'b1;
    @(negedge clk);
    chk("mid_rst.stall_after", 32'(stall_o[2]), 32'd0);
    chk("mid_rst.valid_after", 32'(vout_o[2]), 32'd0);
    mdl[2][4] = 32'hA5A5_0F0F;
    do_op(2, 1, 0, 0, 3'd2, 32'h10, 0, 0, 0, "mid_rst.lw");

    for (int i = 0; i < 60; i++) begin
      rs   = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 4));
      ra   = (rs == 0) ? $urandom : (32'h100 + 32'($urandom_range(0, 15)));
      rdat = $urandom;
      rb1  = $urandom;
      rb2  = ($urandom_range(0, 2) == 0) ? rb1 : $urandom;
      f3   = 3'($urandom_range(0, 7));
      case (kind)
        0:       do_op(rs, 1, 0, 0, f3, ra, rdat, 0, 0, "rnd.load");
        1:       do_op(rs, 0, 1, 0, f3, ra, rdat, 0, 0, "rnd.store");
        2:       do_op(rs, 0, 0, 1, f3, ra, 0, rb1, rb2, "rnd.branch");
        3:       do_op(rs, 1, 1, 0, f3, ra, rdat, 0, 0, "rnd.rdwr");
        default: do_op(rs, 1, 0, 0, 3'd2, ra & 32'hFFFF_FFFC, 0, 0, 0, "rnd.lw");
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory-access stage for the five-stage RISC-V pipeline, sitting between EX/MEM and MEM/WB. It owns the data RAM, performs byte/halfword/word loads and stores with sign/zero extension, and models a configurable RAM access latency. While an access is in progress it stalls the pipeline. It resolves all six conditional branches from full operand compare, not a zero flag.

## Interface

Parameters:
- ADDR_W, 10, word-address bits; RAM holds 2^ADDR_W 32-bit words.
- MEM_LAT, 1, access latency in cycles; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  an instruction is present in MEM this cycle.
- alu_result  in  32  byte address for loads and stores.
- write_data  in  32  store data, taken from rs2.
- rs1_val, rs2_val  in  32 each  branch compare operands.
- mem_read, mem_write, mem_branch  in  1 each  control bits from EX/MEM.
- funct3  in  3  access size, or branch condition.
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- valid_out  out  1  the MEM result is final this cycle; MEM/WB may capture it.
- load_data  out  32  extended load result.
- mem_fault  out  1  misaligned or illegal access; no access is performed.
- pc_src  out  1  branch taken.

## Operation

- FSM states are IDLE, BUSY and DONE. A 4-bit counter `cnt` tracks latency.
- A request is `valid_in & (mem_read | mem_write) & ~mem_fault`, evaluated only in IDLE.
- Accept edge, IDLE with a request:
  - Load: the RAM word is read into the read register.
  - Store: the byte-enabled write commits to RAM on this edge.
  - `cnt` is set to MEM_LAT-1.
  - Next state is BUSY if MEM_LAT>1, otherwise DONE.
- BUSY: `cnt` decrements each cycle; the FSM enters DONE when `cnt`==1.
- DONE: lasts one cycle, then returns to IDLE. No request is accepted in DONE, because the inputs still hold the same instruction.
- Store sizes by funct3: 000 SB (byte lane addr[1:0]), 001 SH (lane addr[1]), 010 SW.
- Load sizes by funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The lane is selected by the registered addr[1:0].
- mem_fault=1 (combinational, gated by valid_in) when any of:
  - mem_read and mem_write are both set;
  - the funct3 value is not listed above for the active operation;
  - a halfword access has addr[0]=1;
  - a word access has addr[1:0]≠0.
  A faulting instruction behaves as a non-memory op: no write, load_data=0.
- Addressing: word index is alu_result[ADDR_W+1:2]; upper bits are ignored, so addresses wrap.
- Branches: pc_src = valid_in & mem_branch & cond, where cond by funct3 is:
  - 000 ==, 001 ≠;
  - 100 signed <, 101 signed ≥;
  - 110 unsigned <, 111 unsigned ≥;
  - 010 and 011 give 0.
  A branch with no memory op is evaluated in IDLE only.
- stall = (IDLE & request) | BUSY.
- valid_out:
  - `(IDLE & valid_in & ~request) | DONE` in general;
  - for a faulting instruction it is valid_in in IDLE.
- load_data:
  - in DONE, the extended load value (0 for a store);
  - on a non-memory valid_out cycle, 0;
  - otherwise it holds its last value.

## Timing

- Reset: state=IDLE, cnt=0, read register=0, so load_data=0. stall, valid_out and pc_src are 0 while rst_n=0.
- RAM contents are not reset.
- Memory op accepted at cycle T:
  - stall=1 for cycles T..T+MEM_LAT-1;
  - valid_out=1 with data in cycle T+MEM_LAT;
  - the next request is eligible at T+MEM_LAT+1.
- Non-memory op, or faulting op: valid_out=1 in the same cycle, with zero stall.
- Back-to-back loads: throughput is one access per MEM_LAT+1 cycles.
- Load after store to the same address: the next access reads the stored value, since the write committed on its accept edge.
- Reset mid-access: the FSM returns to IDLE on the next edge and stall drops. A store whose accept edge has passed remains committed.

## Test plan

- MEM_LAT=1: SW 0xDEADBEEF to 0x40, then LW 0x40. Each access gives stall=1 for 1 cycle and valid_out in the next. The load returns 0xDEADBEEF.
- MEM_LAT=3:
  - SB 0x80 to 0x41, then LB 0x41 → 0xFFFFFF80, with stall high 3 cycles.
  - LBU 0x41 → 0x00000080.
  - LH 0x40 → 0xFFFF80EF.
- Misaligned LW at 0x42 and LH at 0x43 → mem_fault=1, stall=0, valid_out=1, load_data=0. The RAM is unchanged.
- Branches with rs1=0xFFFFFFFF, rs2=1: BLT (100) pc_src=1, BLTU (110) pc_src=0, BGEU (111) pc_src=1, BNE pc_src=1. funct3=010 gives pc_src=0, and mem_branch=0 gives pc_src=0.
- MEM_LAT=4: assert rst_n=0 in the 2nd stall cycle of an SW to 0x10. The next cycle shows state IDLE and stall=0. After reset, LW 0x10 returns the stored value.
- Address wrap with ADDR_W=4: SW to 0x44 followed by LW 0x04 returns the same data.
